// File: rtl/poly_nco.sv
// Polyphonic NCO: per-voice phase accumulators shaped into triangle/saw/square,
// weighted and time-multiplexed into one mixed unsigned sample per sample period.
module poly_nco #(
  parameter int CPU_CLOCK_FREQ = 100_000_000,
  parameter int SAMPLE_RATE    = 1_000_000,
  parameter int VOICES         = 4,
  parameter int PHASE_W        = 24,
  parameter int OUT_W          = 12,
  localparam int VW            = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [VW-1:0]      cfg_voice,
  input  logic [1:0]         cfg_addr,
  input  logic [PHASE_W-1:0] cfg_data,
  output logic [OUT_W-1:0]   wave,
  output logic               wave_valid
);

  localparam int CLKS  = CPU_CLOCK_FREQ / SAMPLE_RATE;
  localparam int CNT_W = (CLKS > 2) ? $clog2(CLKS) : 1;
  localparam int LV    = $clog2(VOICES);
  localparam int SHIFT = 5 + LV;
  localparam int ACC_W = OUT_W + SHIFT;
  localparam int CW    = OUT_W + 5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [VW-1:0]      idx_q;
  logic [ACC_W-1:0]   acc_q, acc_next;
  logic               tick, last;

  logic [PHASE_W-1:0] phase_q [VOICES];
  logic [PHASE_W-1:0] inc_q   [VOICES];
  logic [2:0]         w_tri_q [VOICES];
  logic [2:0]         w_saw_q [VOICES];
  logic [2:0]         w_sq_q  [VOICES];
  logic [7:0]         duty_q  [VOICES];
  logic               en_q    [VOICES];

  logic [OUT_W-1:0]   p_v, tri_v, sq_v;
  logic [CW-1:0]      contrib;

  // Triangle folds the upper half of the ramp back down at double slope.
  function automatic logic [OUT_W-1:0] tri_shape(input logic [OUT_W-1:0] p);
    logic [OUT_W-1:0] s;
    s = p << 1;
    return p[OUT_W-1] ? ~s : s;
  endfunction

  function automatic logic [OUT_W-1:0] sq_shape(input logic [7:0] p_top, input logic [7:0] duty);
    return (p_top < duty) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
  endfunction

  assign tick = (cnt_q == CNT_W'(CLKS - 1));
  assign last = (idx_q == VW'(VOICES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (tick) state_d = RUN;
      end
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage: shape and weight the voice selected by idx_q.
  always_comb begin
    p_v     = phase_q[idx_q][PHASE_W-1 -: OUT_W];
    tri_v   = tri_shape(p_v);
    sq_v    = sq_shape(p_v[OUT_W-1 -: 8], duty_q[idx_q]);
    contrib = '0;
    if (en_q[idx_q])
      contrib = CW'(w_tri_q[idx_q]) * CW'(tri_v)
              + CW'(w_saw_q[idx_q]) * CW'(p_v)
              + CW'(w_sq_q[idx_q])  * CW'(sq_v);
    acc_next = acc_q + ACC_W'(contrib);
  end

  // Stage: accumulate, advance phases, and publish the mix as the last voice lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      acc_q      <= '0;
      wave       <= '0;
      wave_valid <= 1'b0;
      for (int v = 0; v < VOICES; v++) begin
        phase_q[v] <= '0;
        inc_q[v]   <= '0;
        w_tri_q[v] <= '0;
        w_saw_q[v] <= '0;
        w_sq_q[v]  <= '0;
        duty_q[v]  <= 8'd128;
        en_q[v]    <= 1'b0;
      end
    end else begin
      wave_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          idx_q <= '0;
          acc_q <= '0;
          if (cfg_valid) begin
            case (cfg_addr)
              2'd0: inc_q[cfg_voice] <= cfg_data;
              2'd1: begin
                w_tri_q[cfg_voice] <= cfg_data[2:0];
                w_saw_q[cfg_voice] <= cfg_data[5:3];
                w_sq_q[cfg_voice]  <= cfg_data[8:6];
              end
              2'd2: duty_q[cfg_voice] <= cfg_data[7:0];
              default: begin
                en_q[cfg_voice] <= cfg_data[0];
                if (cfg_data[1]) phase_q[cfg_voice] <= '0;
              end
            endcase
          end
        end
        RUN: begin
          acc_q <= acc_next;
          idx_q <= idx_q + 1'b1;
          if (en_q[idx_q]) phase_q[idx_q] <= phase_q[idx_q] + inc_q[idx_q];
          if (last) begin
            wave       <= acc_next[ACC_W-1 -: OUT_W];
            wave_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
